// File: rtl/spi_ram_burst_if.sv
// Command/read-data handshake bundle for spi_ram_burst.
// rx_*: command words in; tx_*: read data out.
interface spi_ram_burst_if #(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
);
    localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int PW     = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    logic              rx_valid;
    logic              rx_ready;
    logic [PW+1:0]     rx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;

    modport slave (
        input  rx_valid, rx_data, tx_ready,
        output rx_ready, tx_valid, tx_data
    );

    modport master (
        output rx_valid, rx_data, tx_ready,
        input  rx_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/spi_ram_burst.sv
// Command-decoded burst RAM behind the SPI slave.
// Ports: clk, rst_n, bus (slave modport), addr_err/wrap pulses.
module spi_ram_burst #(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1,
    parameter int RD_LAT    = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_ram_burst_if.slave bus,
    output logic           addr_err,
    output logic           wrap
);
    localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int PW     = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PIPE,
        S_TX
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] pipe_data;

    logic [1:0]        op;
    logic [PW-1:0]     pay;
    logic [ADDR_W-1:0] pay_addr;
    logic              pay_ok;
    logic              accept;
    logic              is_wa;
    logic              is_wd;
    logic              is_ra;
    logic              is_rd;

    assign op       = bus.rx_data[PW+1:PW];
    assign pay      = bus.rx_data[PW-1:0];
    assign pay_addr = pay[ADDR_W-1:0];
    assign pay_ok   = {1'b0, pay_addr} < DEPTH_C;
    assign accept   = bus.rx_valid && bus.rx_ready;
    assign is_wa    = accept && (op == 2'b00);
    assign is_wd    = accept && (op == 2'b01);
    assign is_ra    = accept && (op == 2'b10);
    assign is_rd    = accept && (op == 2'b11);

    function automatic logic [ADDR_W-1:0] inc(
        input logic [ADDR_W-1:0] a
    );
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction

    // Storage has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (is_wd) begin
            mem[wr_addr] <= pay[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wr_addr      <= '0;
            rd_addr      <= '0;
            pipe_data    <= '0;
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            bus.rx_ready <= 1'b1;
            addr_err     <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            wrap     <= 1'b0;

            unique case (1'b1)
                is_wa: begin
                    if (pay_ok) wr_addr <= pay_addr;
                    else        addr_err <= 1'b1;
                end
                is_ra: begin
                    if (pay_ok) rd_addr <= pay_addr;
                    else        addr_err <= 1'b1;
                end
                is_wd: begin
                    if (AUTO_INC != 0) begin
                        wr_addr <= inc(wr_addr);
                        wrap    <= (wr_addr == LAST);
                    end
                end
                is_rd: begin
                    if (AUTO_INC != 0) begin
                        rd_addr <= inc(rd_addr);
                        wrap    <= (rd_addr == LAST);
                    end
                end
                default: ;
            endcase

            // rx_ready stays low from read accept until tx handshake,
            // so only one read is ever outstanding.
            case (state)
                S_IDLE: begin
                    if (is_rd) begin
                        bus.rx_ready <= 1'b0;
                        if (RD_LAT == 1) begin
                            bus.tx_data  <= mem[rd_addr];
                            bus.tx_valid <= 1'b1;
                            state        <= S_TX;
                        end else begin
                            pipe_data <= mem[rd_addr];
                            state     <= S_PIPE;
                        end
                    end
                end
                S_PIPE: begin
                    bus.tx_data  <= pipe_data;
                    bus.tx_valid <= 1'b1;
                    state        <= S_TX;
                end
                S_TX: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        bus.rx_ready <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst in three configurations.
// d0: defaults; d1: depth 200, latency 2; d2: no auto-increment.
module tb_spi_ram_burst;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ae0, ae1, ae2;
    logic wr0, wr1, wr2;
    int   wc0 = 0;
    int   wc1 = 0;
    int   wc2 = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    spi_ram_burst_if #(.MEM_DEPTH(256)) b0 ();
    spi_ram_burst_if #(.MEM_DEPTH(200)) b1 ();
    spi_ram_burst_if #(.MEM_DEPTH(256)) b2 ();

    spi_ram_burst u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave),
        .addr_err(ae0), .wrap(wr0)
    );
    spi_ram_burst #(.MEM_DEPTH(200), .RD_LAT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave),
        .addr_err(ae1), .wrap(wr1)
    );
    spi_ram_burst #(.AUTO_INC(0)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave),
        .addr_err(ae2), .wrap(wr2)
    );

    always @(posedge clk) begin
        if (wr0) wc0 <= wc0 + 1;
        if (wr1) wc1 <= wc1 + 1;
        if (wr2) wc2 <= wc2 + 1;
    end

    task automatic drive(input int d, input logic v, input logic [9:0] w);
        case (d)
            0: begin b0.rx_valid = v; b0.rx_data = w; end
            1: begin b1.rx_valid = v; b1.rx_data = w; end
            default: begin b2.rx_valid = v; b2.rx_data = w; end
        endcase
    endtask

    task automatic peek(input int d, output logic tv,
                        output logic [7:0] td, output logic rr);
        case (d)
            0: begin tv = b0.tx_valid; td = b0.tx_data; rr = b0.rx_ready; end
            1: begin tv = b1.tx_valid; td = b1.tx_data; rr = b1.rx_ready; end
            default: begin tv = b2.tx_valid; td = b2.tx_data; rr = b2.rx_ready; end
        endcase
    endtask

    task automatic send(input int d, input logic [1:0] op,
                        input logic [7:0] pl);
        drive(d, 1'b1, {op, pl});
        @(posedge clk); #1;
        drive(d, 1'b0, 10'h000);
    endtask

    // Issues a read with tx_ready=1; reports latency, data and handshake.
    task automatic read_word(input int d, output int lat,
                             output logic [7:0] data, output logic rlo,
                             output logic rdy_after, output logic tv_after);
        logic tv;
        logic rr;
        int   n;
        send(d, 2'b11, 8'h00);
        n   = 1;
        rlo = 1'b1;
        peek(d, tv, data, rr);
        if (rr) rlo = 1'b0;
        while (!tv && n < 8) begin
            @(posedge clk); #1;
            n++;
            peek(d, tv, data, rr);
            if (rr) rlo = 1'b0;
        end
        lat = tv ? n : 0;
        @(posedge clk); #1;
        peek(d, tv_after, data, rdy_after);
        peek(d, tv, data, rr);
    endtask

    task automatic test_reset;
        logic tv; logic [7:0] td; logic rr;
        peek(0, tv, td, rr);
        total++; if (tv !== 1'b0) begin bad++; $display("FAIL rst_tv got %b want 0", tv); end
        total++; if (td !== 8'h00) begin bad++; $display("FAIL rst_td got %h want 00", td); end
        total++; if (rr !== 1'b1) begin bad++; $display("FAIL rst_rr got %b want 1", rr); end
        total++; if ({ae0, wr0} !== 2'b00) begin bad++; $display("FAIL rst_pulses got %b want 00", {ae0, wr0}); end
        peek(1, tv, td, rr);
        total++; if ({tv, rr} !== 2'b01) begin bad++; $display("FAIL rst_d1 got %b want 01", {tv, rr}); end
    endtask

    task automatic test_single;
        logic tv; logic [7:0] td; logic rr;
        int lat; logic rlo, ra, tva;
        send(0, 2'b00, 8'h10);
        send(0, 2'b01, 8'hA5);
        send(0, 2'b10, 8'h10);
        peek(0, tv, td, rr);
        total++; if (tv !== 1'b0) begin bad++; $display("FAIL single_pre_tv got %b want 0", tv); end
        read_word(0, lat, td, rlo, ra, tva);
        total++; if (lat !== 1) begin bad++; $display("FAIL single_lat got %0d want 1", lat); end
        total++; if (td !== 8'hA5) begin bad++; $display("FAIL single_data got %h want a5", td); end
        total++; if (rlo !== 1'b1) begin bad++; $display("FAIL single_rr_low got %b want 1", rlo); end
        total++; if ({ra, tva} !== 2'b10) begin bad++; $display("FAIL single_hs got %b want 10", {ra, tva}); end
    endtask

    task automatic test_burst;
        logic [7:0] td; int lat; logic rlo, ra, tva;
        int w0;
        w0 = wc0;
        send(0, 2'b00, 8'hFE);
        send(0, 2'b01, 8'h11);
        send(0, 2'b01, 8'h22);
        send(0, 2'b01, 8'h33);
        @(posedge clk); #1;
        total++; if (wc0 - w0 !== 1) begin bad++; $display("FAIL burst_wr_wrap got %0d want 1", wc0 - w0); end
        w0 = wc0;
        send(0, 2'b10, 8'hFE);
        read_word(0, lat, td, rlo, ra, tva);
        total++; if (td !== 8'h11) begin bad++; $display("FAIL burst_rd0 got %h want 11", td); end
        read_word(0, lat, td, rlo, ra, tva);
        total++; if (td !== 8'h22) begin bad++; $display("FAIL burst_rd1 got %h want 22", td); end
        read_word(0, lat, td, rlo, ra, tva);
        total++; if (td !== 8'h33) begin bad++; $display("FAIL burst_rd2 got %h want 33", td); end
        @(posedge clk); #1;
        total++; if (wc0 - w0 !== 1) begin bad++; $display("FAIL burst_rd_wrap got %0d want 1", wc0 - w0); end
    endtask

    task automatic test_backpressure;
        logic tv; logic [7:0] td; logic rr;
        int lat; logic rlo, ra, tva;
        int stall_bad;
        send(0, 2'b00, 8'h40);
        send(0, 2'b01, 8'hC3);
        send(0, 2'b01, 8'h99);
        send(0, 2'b01, 8'h77);
        send(0, 2'b10, 8'h40);
        b0.tx_ready = 1'b0;
        send(0, 2'b11, 8'h00);
        peek(0, tv, td, rr);
        total++; if ({tv, rr, td} !== {2'b10, 8'hC3}) begin bad++; $display("FAIL bp_first got %b%b %h want 10 c3", tv, rr, td); end
        drive(0, 1'b1, {2'b10, 8'h42});
        stall_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            peek(0, tv, td, rr);
            if ({tv, rr, td} !== {2'b10, 8'hC3}) stall_bad++;
        end
        total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_stall got %0d bad cycles want 0", stall_bad); end
        drive(0, 1'b0, 10'h000);
        b0.tx_ready = 1'b1;
        @(posedge clk); #1;
        peek(0, tv, td, rr);
        total++; if ({tv, rr} !== 2'b01) begin bad++; $display("FAIL bp_release got %b want 01", {tv, rr}); end
        read_word(0, lat, td, rlo, ra, tva);
        total++; if (td !== 8'h99) begin bad++; $display("FAIL bp_blocked_cmd got %h want 99", td); end
    endtask

    task automatic test_addr_err;
        logic [7:0] td; int lat; logic rlo, ra, tva;
        send(1, 2'b00, 8'h20);
        send(1, 2'b01, 8'h3C);
        send(1, 2'b00, 8'hFA);
        total++; if (ae1 !== 1'b1) begin bad++; $display("FAIL err_pulse got %b want 1", ae1); end
        @(posedge clk); #1;
        total++; if (ae1 !== 1'b0) begin bad++; $display("FAIL err_clear got %b want 0", ae1); end
        send(1, 2'b01, 8'h4D);
        send(1, 2'b10, 8'h20);
        read_word(1, lat, td, rlo, ra, tva);
        total++; if (lat !== 2) begin bad++; $display("FAIL lat2 got %0d want 2", lat); end
        total++; if (td !== 8'h3C) begin bad++; $display("FAIL lat2_data got %h want 3c", td); end
        read_word(1, lat, td, rlo, ra, tva);
        total++; if (td !== 8'h4D) begin bad++; $display("FAIL err_addr_kept got %h want 4d", td); end
        send(1, 2'b10, 8'hC8);
        total++; if (ae1 !== 1'b1) begin bad++; $display("FAIL err_depth got %b want 1", ae1); end
        send(1, 2'b00, 8'hC7);
        total++; if (ae1 !== 1'b0) begin bad++; $display("FAIL err_last got %b want 0", ae1); end
        send(1, 2'b01, 8'h01);
        total++; if (wr1 !== 1'b1) begin bad++; $display("FAIL wrap199 got %b want 1", wr1); end
        send(1, 2'b01, 8'h02);
        total++; if (wr1 !== 1'b0) begin bad++; $display("FAIL wrap_once got %b want 0", wr1); end
        send(1, 2'b10, 8'hC7);
        read_word(1, lat, td, rlo, ra, tva);
        total++; if (td !== 8'h01) begin bad++; $display("FAIL rd199 got %h want 01", td); end
        read_word(1, lat, td, rlo, ra, tva);
        total++; if (td !== 8'h02) begin bad++; $display("FAIL rd_wrap0 got %h want 02", td); end
    endtask

    task automatic test_no_inc;
        logic [7:0] td; int lat; logic rlo, ra, tva;
        int w2;
        w2 = wc2;
        send(2, 2'b00, 8'h04);
        send(2, 2'b01, 8'h77);
        send(2, 2'b00, 8'h03);
        send(2, 2'b01, 8'h5A);
        send(2, 2'b01, 8'h6B);
        send(2, 2'b10, 8'h03);
        read_word(2, lat, td, rlo, ra, tva);
        total++; if (td !== 8'h6B) begin bad++; $display("FAIL noinc_m3 got %h want 6b", td); end
        read_word(2, lat, td, rlo, ra, tva);
        total++; if (td !== 8'h6B) begin bad++; $display("FAIL noinc_hold got %h want 6b", td); end
        send(2, 2'b10, 8'h04);
        read_word(2, lat, td, rlo, ra, tva);
        total++; if (td !== 8'h77) begin bad++; $display("FAIL noinc_m4 got %h want 77", td); end
        total++; if (wc2 - w2 !== 0) begin bad++; $display("FAIL noinc_wrap got %0d want 0", wc2 - w2); end
    endtask

    task automatic test_reset_mid_read;
        logic tv; logic [7:0] td; logic rr;
        int lat; logic rlo, ra, tva;
        drive(0, 1'b1, {2'b11, 8'h00});
        drive(1, 1'b1, {2'b11, 8'h00});
        @(posedge clk); #1;
        drive(0, 1'b0, 10'h000);
        drive(1, 1'b0, 10'h000);
        peek(0, tv, td, rr);
        total++; if ({tv, rr} !== 2'b10) begin bad++; $display("FAIL mid_pre got %b want 10", {tv, rr}); end
        rst_n = 1'b0;
        #1;
        peek(0, tv, td, rr);
        total++; if ({tv, rr, td} !== {2'b01, 8'h00}) begin bad++; $display("FAIL mid_d0 got %b%b %h want 01 00", tv, rr, td); end
        peek(1, tv, td, rr);
        total++; if ({tv, rr} !== 2'b01) begin bad++; $display("FAIL mid_d1 got %b want 01", {tv, rr}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        peek(1, tv, td, rr);
        total++; if ({tv, rr} !== 2'b01) begin bad++; $display("FAIL mid_stale got %b want 01", {tv, rr}); end
        read_word(0, lat, td, rlo, ra, tva);
        total++; if (td !== 8'h33) begin bad++; $display("FAIL mid_addr0 got %h want 33", td); end
        read_word(1, lat, td, rlo, ra, tva);
        total++; if ({lat[1:0], td} !== {2'd2, 8'h02}) begin bad++; $display("FAIL mid_d1_addr0 got %0d %h want 2 02", lat, td); end
        send(0, 2'b10, 8'h40);
        read_word(0, lat, td, rlo, ra, tva);
        total++; if (td !== 8'hC3) begin bad++; $display("FAIL mid_retained got %h want c3", td); end
    endtask

    initial begin
        drive(0, 1'b0, 10'h000);
        drive(1, 1'b0, 10'h000);
        drive(2, 1'b0, 10'h000);
        b0.tx_ready = 1'b1;
        b1.tx_ready = 1'b1;
        b2.tx_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_single();
        test_burst();
        test_backpressure();
        test_addr_err();
        test_no_inc();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
